// File: rtl/bus_ram_target_pkg.sv
// Shared types and constants for the bus RAM target.
//   t_target_state : responder FSM encoding (IDLE / WAIT / RESP)
//   STROBE_LANE_*  : one-hot strobe per byte lane; lane 0 is byte offset 0,
//                    which sits in data bits [31:24] and strobe bit 3.
package bus_ram_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } t_target_state;

  localparam logic [3:0] STROBE_LANE_0   = 4'b1000;  // data[31:24]
  localparam logic [3:0] STROBE_LANE_1   = 4'b0100;  // data[23:16]
  localparam logic [3:0] STROBE_LANE_2   = 4'b0010;  // data[15:8]
  localparam logic [3:0] STROBE_LANE_3   = 4'b0001;  // data[7:0]
  localparam logic [3:0] STROBE_LANE_ALL = 4'b1111;

  localparam int WAIT_CNT_W = 4;  // wait states range 0..15

endpackage

// File: rtl/bus_ram_target_strobed_ram.sv
// Word RAM built from four 8-bit banks, one per byte lane, so each lane has
// its own write enable. Read is synchronous: o_rdata updates on the edge where
// i_re is high and otherwise holds, which lets the top use it directly as the
// bus read-data register.
// Ports:
//   i_clk, i_rst        clock; synchronous reset clears only the read register
//   i_index [AW]        word index
//   i_we                write enable, qualified per lane by i_strobes
//   i_strobes [4]       bit3 = [31:24] ... bit0 = [7:0]
//   i_wdata [32]        write data
//   i_re                read enable
//   o_rdata [32]        registered read data
module bus_ram_target_strobed_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_index,
  input  logic          i_we,
  input  logic [3:0]    i_strobes,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  output logic [31:0]   o_rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_q;

    // Memory array has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
      if (i_we && i_strobes[l]) begin
        r_mem[i_index] <= i_wdata[8*l +: 8];
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_q <= 8'h00;
      end else if (i_re) begin
        r_q <= r_mem[i_index];
      end
    end

    assign o_rdata[8*l +: 8] = r_q;
  end

endmodule

// File: rtl/bus_ram_target.sv
// Bus-side RAM responder. Decodes the word address against its window,
// optionally inserts WAIT_STATES cycles, then performs the access and pulses
// target_ack (or target_error for read+write together) for one cycle.
// Handshake: read/write are level requests held by the master until it sees
// ack or error; dropping the request during WAIT aborts with no pulse and no
// RAM access; a request still held after the pulse starts a new access.
// Ports:
//   clock, reset                  clock; synchronous active-high reset
//   businterface_address [30]     word address [31:2]
//   businterface_data_out [32]    write data (big-endian lanes)
//   businterface_data_strobes [4] lane enables, bit3 = [31:24]
//   businterface_read/_write      level requests
//   target_data_out [32]          read data, holds last read value
//   target_ack, target_error      one-cycle response pulses
//   o_debug_state                 current FSM state
module bus_ram_target
  import bus_ram_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [29:0]   businterface_address,
  input  logic [31:0]   businterface_data_out,
  input  logic [3:0]    businterface_data_strobes,
  input  logic          businterface_read,
  input  logic          businterface_write,
  output logic [31:0]   target_data_out,
  output logic          target_ack,
  output logic          target_error,
  output t_target_state o_debug_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // One extra bit so the window end cannot wrap at the top of the map.
  localparam logic [30:0] BASE_W = {1'b0, BASE_ADDR[31:2]};
  localparam logic [30:0] END_W  = BASE_W + 31'(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  t_target_state           r_state, w_next_state;
  logic [WAIT_CNT_W-1:0]   r_count, w_next_count;
  logic                    r_ack, r_err;
  logic                    w_go_access, w_go_error;
  logic                    w_sel, w_req, w_both;
  logic [30:0]             w_addr_ext;
  logic [AW-1:0]           w_index;

  assign w_addr_ext = {1'b0, businterface_address};
  assign w_sel      = (w_addr_ext >= BASE_W) && (w_addr_ext < END_W);
  assign w_req      = w_sel && (businterface_read || businterface_write);
  assign w_both     = businterface_read && businterface_write;
  assign w_index    = AW'(businterface_address - BASE_ADDR[31:2]);

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_go_access  = 1'b0;
    w_go_error   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_both) begin
            w_next_state = ST_RESP;
            w_go_error   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            w_next_state = ST_RESP;
            w_go_access  = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
            w_next_count = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_next_state = ST_IDLE;
          w_next_count = '0;
        end else if (r_count == WAIT_CNT_W'(1)) begin
          // Inputs may have changed during WAIT; judge them as they are now.
          w_next_state = ST_RESP;
          w_next_count = '0;
          w_go_error   = w_both;
          w_go_access  = !w_both;
        end else begin
          w_next_count = r_count - WAIT_CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
      r_ack   <= w_go_access;
      r_err   <= w_go_error;
    end
  end

  // Reset gates the enables so an access landing on the reset edge is dropped.
  bus_ram_target_strobed_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_index   (w_index),
    .i_we      (w_go_access && businterface_write && !reset),
    .i_strobes (businterface_data_strobes),
    .i_wdata   (businterface_data_out),
    .i_re      (w_go_access && businterface_read && !reset),
    .o_rdata   (target_data_out)
  );

  assign target_ack    = r_ack;
  assign target_error  = r_err;
  assign o_debug_state = r_state;

endmodule

// File: tb/tb_bus_ram_target.sv
module tb_bus_ram_target;
  import bus_ram_target_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Three instances: index 0 -> W=0, 1 -> W=2, 2 -> W=3
  logic [29:0]   addr  [3];
  logic [31:0]   wdata [3];
  logic [3:0]    strb  [3];
  logic          rd    [3];
  logic          wr    [3];
  logic [31:0]   rdata [3];
  logic          ack   [3];
  logic          err   [3];
  t_target_state dstate[3];

  bus_ram_target #(.BASE_ADDR(32'h100), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_w0 (
    .clock(clk), .reset(rst), .businterface_address(addr[0]),
    .businterface_data_out(wdata[0]), .businterface_data_strobes(strb[0]),
    .businterface_read(rd[0]), .businterface_write(wr[0]),
    .target_data_out(rdata[0]), .target_ack(ack[0]), .target_error(err[0]),
    .o_debug_state(dstate[0]));

  bus_ram_target #(.BASE_ADDR(32'h100), .DEPTH_WORDS(256), .WAIT_STATES(2)) u_w2 (
    .clock(clk), .reset(rst), .businterface_address(addr[1]),
    .businterface_data_out(wdata[1]), .businterface_data_strobes(strb[1]),
    .businterface_read(rd[1]), .businterface_write(wr[1]),
    .target_data_out(rdata[1]), .target_ack(ack[1]), .target_error(err[1]),
    .o_debug_state(dstate[1]));

  bus_ram_target #(.BASE_ADDR(32'h100), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_w3 (
    .clock(clk), .reset(rst), .businterface_address(addr[2]),
    .businterface_data_out(wdata[2]), .businterface_data_strobes(strb[2]),
    .businterface_read(rd[2]), .businterface_write(wr[2]),
    .target_data_out(rdata[2]), .target_ack(ack[2]), .target_error(err[2]),
    .o_debug_state(dstate[2]));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with instance k idle. Holds the request until a
  // pulse (or 20 cycles), drops it, then spends one more cycle so the FSM
  // is back in IDLE. lat = cycles from request to pulse, 0 if no pulse.
  task automatic access(input int k, input logic r, input logic w,
                        input logic [31:0] byte_addr, input logic [31:0] d,
                        input logic [3:0] s, output int lat,
                        output logic got_ack, output logic got_err,
                        output logic [31:0] q, output logic after);
    addr[k] = byte_addr[31:2];
    wdata[k] = d;
    strb[k] = s;
    rd[k] = r;
    wr[k] = w;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; q = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        lat = i; got_ack = ack[k]; got_err = err[k]; q = rdata[k];
        break;
      end
    end
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    @(negedge clk);
    after = ack[k] | err[k];
  endtask

  task automatic write_word(input string tag, input int k, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s, input int exp_lat);
    int lat; logic ga, ge, af; logic [31:0] q;
    access(k, 1'b0, 1'b1, a, d, s, lat, ga, ge, q, af);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ack"}, {31'b0, ga}, 32'd1);
    chk({tag, "_pulse1"}, {31'b0, af}, 32'd0);
  endtask

  task automatic read_word(input string tag, input int k, input logic [31:0] a,
                           input logic [31:0] exp_d, input int exp_lat);
    int lat; logic ga, ge, af; logic [31:0] q;
    access(k, 1'b1, 1'b0, a, 32'h0, 4'b0000, lat, ga, ge, q, af);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ack"}, {31'b0, ga}, 32'd1);
    chk({tag, "_err"}, {31'b0, ge}, 32'd0);
    chk({tag, "_data"}, q, exp_d);
    chk({tag, "_pulse1"}, {31'b0, af}, 32'd0);
  endtask

  // Holds a request for n cycles and returns how many pulses appeared.
  task automatic hold_count(input int k, input logic r, input logic w,
                            input logic [31:0] a, input int n, output int pulses);
    addr[k] = a[31:2];
    rd[k] = r;
    wr[k] = w;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) pulses++;
    end
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, pulses;
    int ack_at[3];
    int n_ack, n_errp;
    logic ga, ge, af;
    logic [31:0] q;

    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0; strb[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ack%0d", k), {31'b0, ack[k]}, 32'd0);
      chk($sformatf("reset_err%0d", k), {31'b0, err[k]}, 32'd0);
      chk($sformatf("reset_data%0d", k), rdata[k], 32'h0);
      chk($sformatf("reset_state%0d", k), 32'(dstate[k]), 32'(ST_IDLE));
    end
    rst = 1'b0;
    @(negedge clk);

    // 1: W=0 full write then read
    write_word("t1_wr", 0, 32'h100, 32'h12345678, STROBE_LANE_ALL, 1);
    read_word("t1_rd", 0, 32'h100, 32'h12345678, 1);

    // 2: lane writes merge into the stored word
    write_word("t2_wr_hi", 0, 32'h100, 32'habffffff, STROBE_LANE_0, 1);
    write_word("t2_wr_lo", 0, 32'h100, 32'hffffabcd, STROBE_LANE_2 | STROBE_LANE_3, 1);
    read_word("t2_rd", 0, 32'h100, 32'hab34abcd, 1);
    write_word("t2_wr_nostrb", 0, 32'h100, 32'h00000000, 4'b0000, 1);
    read_word("t2_rd_nostrb", 0, 32'h100, 32'hab34abcd, 1);

    // 5: window edges, unselected addresses, read+write error
    write_word("t5_wr_top", 0, 32'h4FC, 32'h0badf00d, STROBE_LANE_ALL, 1);
    read_word("t5_rd_top", 0, 32'h4FC, 32'h0badf00d, 1);
    hold_count(0, 1'b1, 1'b0, 32'h0FC, 10, pulses);
    chk("t5_below_pulses", 32'(pulses), 32'd0);
    hold_count(0, 1'b1, 1'b0, 32'h500, 10, pulses);
    chk("t5_above_pulses", 32'(pulses), 32'd0);
    access(0, 1'b1, 1'b1, 32'h100, 32'h0, STROBE_LANE_ALL, lat, ga, ge, q, af);
    chk("t5_rw_lat", 32'(lat), 32'd1);
    chk("t5_rw_err", {31'b0, ge}, 32'd1);
    chk("t5_rw_noack", {31'b0, ga}, 32'd0);
    chk("t5_rw_datahold", q, 32'h0badf00d);
    chk("t5_rw_pulse1", {31'b0, af}, 32'd0);
    read_word("t5_rd_after", 0, 32'h100, 32'hab34abcd, 1);

    // 3: W=2 latency and back-to-back throughput
    write_word("t3_wr", 1, 32'h104, 32'hcafef00d, STROBE_LANE_ALL, 3);
    read_word("t3_rd", 1, 32'h104, 32'hcafef00d, 3);
    addr[1] = 30'(32'h104 >> 2);
    rd[1] = 1'b1;
    n_ack = 0; n_errp = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (err[1]) n_errp++;
      if (ack[1]) begin
        if (n_ack < 3) ack_at[n_ack] = i;
        n_ack++;
      end
    end
    rd[1] = 1'b0;
    @(negedge clk);
    chk("t3_b2b_count", 32'(n_ack), 32'd3);
    chk("t3_b2b_first", 32'(ack_at[0]), 32'd3);
    chk("t3_b2b_gap1", 32'(ack_at[1] - ack_at[0]), 32'd4);
    chk("t3_b2b_gap2", 32'(ack_at[2] - ack_at[1]), 32'd4);
    chk("t3_b2b_noerr", 32'(n_errp), 32'd0);

    // 4: W=2 write aborted after one cycle
    write_word("t4_wr_init", 1, 32'h108, 32'h11112222, STROBE_LANE_ALL, 3);
    hold_count(1, 1'b0, 1'b1, 32'h108, 0, pulses);
    addr[1] = 30'(32'h108 >> 2);
    wdata[1] = 32'hdeadbeef;
    strb[1] = STROBE_LANE_ALL;
    wr[1] = 1'b1;
    @(negedge clk);
    chk("t4_in_wait", 32'(dstate[1]), 32'(ST_WAIT));
    wr[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[1] || err[1]) pulses++;
    end
    chk("t4_abort_pulses", 32'(pulses), 32'd0);
    chk("t4_abort_state", 32'(dstate[1]), 32'(ST_IDLE));
    read_word("t4_rd", 1, 32'h108, 32'h11112222, 3);

    // 6: W=3 reset in WAIT discards the write and clears outputs
    write_word("t6_wr_init", 2, 32'h10C, 32'h55aa55aa, STROBE_LANE_ALL, 4);
    read_word("t6_rd_init", 2, 32'h10C, 32'h55aa55aa, 4);
    addr[2] = 30'(32'h10C >> 2);
    wdata[2] = 32'hffffffff;
    strb[2] = STROBE_LANE_ALL;
    wr[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_pre_state", 32'(dstate[2]), 32'(ST_WAIT));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ack", {31'b0, ack[2]}, 32'd0);
    chk("t6_rst_err", {31'b0, err[2]}, 32'd0);
    chk("t6_rst_data", rdata[2], 32'h0);
    chk("t6_rst_state", 32'(dstate[2]), 32'(ST_IDLE));
    rst = 1'b0;
    wr[2] = 1'b0;
    @(negedge clk);
    read_word("t6_rd_after", 2, 32'h10C, 32'h55aa55aa, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
